// File: rtl/bus_c_register_bank_if.sv
// Bus-C write port and register-bank outputs, grouped for the control
// unit (master) and the register bank (slave).
interface bus_c_register_bank_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int INSTR_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]  BUS_C;
    logic                   WRITE_EN;
    logic [3:0]             WRITE_SEL;
    logic                   INC_EN;
    logic [3:0]             INC_SEL;
    logic [DATA_WIDTH-1:0]  PC;
    logic [DATA_WIDTH-1:0]  R1;
    logic [DATA_WIDTH-1:0]  R2;
    logic [DATA_WIDTH-1:0]  TR;
    logic [DATA_WIDTH-1:0]  R;
    logic [DATA_WIDTH-1:0]  AC;
    logic [DATA_WIDTH-1:0]  AR;
    logic [INSTR_WIDTH-1:0] IR;
    logic                   Z_AC;
    logic                   WRITE_ACK;
    logic                   SEL_ERR;

    modport master (
        output BUS_C, WRITE_EN, WRITE_SEL, INC_EN, INC_SEL,
        input  PC, R1, R2, TR, R, AC, AR, IR,
        input  Z_AC, WRITE_ACK, SEL_ERR
    );

    modport slave (
        input  BUS_C, WRITE_EN, WRITE_SEL, INC_EN, INC_SEL,
        output PC, R1, R2, TR, R, AC, AR, IR,
        output Z_AC, WRITE_ACK, SEL_ERR
    );
endinterface

// File: rtl/bus_c_register_bank.sv
// Architectural register bank loaded from BUS_C, with per-register increment.
// Define INC_SATURATE_EN to make increments saturate at all-ones instead of wrapping.
module bus_c_register_bank #(
    parameter int                  DATA_WIDTH  = 16,
    parameter int                  INSTR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    bus_c_register_bank_if.slave  bus
);
    localparam logic [3:0] SEL_PC = 4'd1;
    localparam logic [3:0] SEL_R1 = 4'd2;
    localparam logic [3:0] SEL_R2 = 4'd3;
    localparam logic [3:0] SEL_TR = 4'd4;
    localparam logic [3:0] SEL_R  = 4'd5;
    localparam logic [3:0] SEL_AC = 4'd6;
    localparam logic [3:0] SEL_IR = 4'd7;
    localparam logic [3:0] SEL_AR = 4'd8;

    logic [DATA_WIDTH-1:0]  pc_q, pc_d, r1_q, r1_d, r2_q, r2_d, tr_q, tr_d;
    logic [DATA_WIDTH-1:0]  r_q, r_d, ac_q, ac_d, ar_q, ar_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   ack_q, ack_d, err_q, err_d;
    logic                   wr_legal, inc_legal, inc_go;

    function automatic logic [DATA_WIDTH-1:0] bump(input logic [DATA_WIDTH-1:0] v);
`ifdef INC_SATURATE_EN
        bump = (&v) ? v : v + DATA_WIDTH'(1);
`else
        bump = v + DATA_WIDTH'(1);
`endif
    endfunction

    always_comb begin
        pc_d = pc_q;
        r1_d = r1_q;
        r2_d = r2_q;
        tr_d = tr_q;
        r_d  = r_q;
        ac_d = ac_q;
        ar_d = ar_q;
        ir_d = ir_q;
        wr_legal  = bus.WRITE_EN && (bus.WRITE_SEL != 4'd0)
                    && (bus.WRITE_SEL <= SEL_AR);
        inc_legal = bus.INC_EN && (bus.INC_SEL != 4'd0)
                    && (bus.INC_SEL <= SEL_AR) && (bus.INC_SEL != SEL_IR);
        // A write to the same register takes priority over its increment.
        inc_go = inc_legal && !(wr_legal && (bus.WRITE_SEL == bus.INC_SEL));
        if (inc_go) begin
            case (bus.INC_SEL)
                SEL_PC:  pc_d = bump(pc_q);
                SEL_R1:  r1_d = bump(r1_q);
                SEL_R2:  r2_d = bump(r2_q);
                SEL_TR:  tr_d = bump(tr_q);
                SEL_R:   r_d  = bump(r_q);
                SEL_AC:  ac_d = bump(ac_q);
                SEL_AR:  ar_d = bump(ar_q);
                default: ;
            endcase
        end
        if (wr_legal) begin
            case (bus.WRITE_SEL)
                SEL_PC:  pc_d = bus.BUS_C;
                SEL_R1:  r1_d = bus.BUS_C;
                SEL_R2:  r2_d = bus.BUS_C;
                SEL_TR:  tr_d = bus.BUS_C;
                SEL_R:   r_d  = bus.BUS_C;
                SEL_AC:  ac_d = bus.BUS_C;
                SEL_IR:  ir_d = bus.BUS_C[INSTR_WIDTH-1:0];
                SEL_AR:  ar_d = bus.BUS_C;
                default: ;
            endcase
        end
        ack_d = wr_legal;
        err_d = (bus.WRITE_EN && !wr_legal) || (bus.INC_EN && !inc_legal);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q  <= RESET_PC;
            r1_q  <= '0;
            r2_q  <= '0;
            tr_q  <= '0;
            r_q   <= '0;
            ac_q  <= '0;
            ar_q  <= '0;
            ir_q  <= '0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            r1_q  <= r1_d;
            r2_q  <= r2_d;
            tr_q  <= tr_d;
            r_q   <= r_d;
            ac_q  <= ac_d;
            ar_q  <= ar_d;
            ir_q  <= ir_d;
            ack_q <= ack_d;
            err_q <= err_d;
        end
    end

    assign bus.PC        = pc_q;
    assign bus.R1        = r1_q;
    assign bus.R2        = r2_q;
    assign bus.TR        = tr_q;
    assign bus.R         = r_q;
    assign bus.AC        = ac_q;
    assign bus.AR        = ar_q;
    assign bus.IR        = ir_q;
    assign bus.Z_AC      = (ac_q == '0);
    assign bus.WRITE_ACK = ack_q;
    assign bus.SEL_ERR   = err_q;
endmodule

// File: tb/tb_bus_c_register_bank.sv
// Scoreboard bench for bus_c_register_bank: directed stimulus pushes
// hand-computed register snapshots, a monitor compares them after each edge.
module tb_bus_c_register_bank;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    bus_c_register_bank_if #(.DATA_WIDTH(16), .INSTR_WIDTH(8)) bus ();

    bus_c_register_bank #(
        .DATA_WIDTH(16), .INSTR_WIDTH(8), .RESET_PC(16'h0000)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .bus(bus)
    );

    typedef struct packed {
        logic [8:1][15:0] r;
        logic             ack;
        logic             err;
    } exp_t;

    exp_t             sb_q[$];
    logic [8:1][15:0] exp_r;
    int               checks = 0;
    int               passes = 0;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " PC"}, bus.PC, 16'h0000);
        chk({tag, " R1"}, bus.R1, 16'h0000);
        chk({tag, " R2"}, bus.R2, 16'h0000);
        chk({tag, " TR"}, bus.TR, 16'h0000);
        chk({tag, " R"},  bus.R,  16'h0000);
        chk({tag, " AC"}, bus.AC, 16'h0000);
        chk({tag, " AR"}, bus.AR, 16'h0000);
        chk({tag, " IR"}, {8'h00, bus.IR}, 16'h0000);
        chk({tag, " Z_AC"}, {15'h0, bus.Z_AC}, 16'h0001);
        chk({tag, " ACK"}, {15'h0, bus.WRITE_ACK}, 16'h0000);
        chk({tag, " ERR"}, {15'h0, bus.SEL_ERR}, 16'h0000);
    endtask

    // Drive one cycle of stimulus and queue the state expected after the edge.
    task automatic step(input logic we, input logic [3:0] ws, input logic [15:0] d,
                        input logic ie, input logic [3:0] is,
                        input logic ack, input logic err);
        exp_t e;
        @(negedge clk);
        bus.WRITE_EN  = we;
        bus.WRITE_SEL = ws;
        bus.BUS_C     = d;
        bus.INC_EN    = ie;
        bus.INC_SEL   = is;
        e.r   = exp_r;
        e.ack = ack;
        e.err = err;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [8:1][15:0] act;
            e = sb_q.pop_front();
            act[1] = bus.PC;
            act[2] = bus.R1;
            act[3] = bus.R2;
            act[4] = bus.TR;
            act[5] = bus.R;
            act[6] = bus.AC;
            act[7] = {8'h00, bus.IR};
            act[8] = bus.AR;
            for (int k = 1; k <= 8; k++)
                chk($sformatf("reg code %0d", k), act[k], e.r[k]);
            chk("Z_AC", {15'h0, bus.Z_AC}, {15'h0, (e.r[6] == 16'h0)});
            chk("WRITE_ACK", {15'h0, bus.WRITE_ACK}, {15'h0, e.ack});
            chk("SEL_ERR", {15'h0, bus.SEL_ERR}, {15'h0, e.err});
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        logic [7:0] lo;
        bus.BUS_C = '0;
        bus.WRITE_EN = 1'b0;
        bus.WRITE_SEL = '0;
        bus.INC_EN = 1'b0;
        bus.INC_SEL = '0;
        exp_r = '0;

        // async reset before any clock edge
        #3 rst_n = 1'b0;
        #1 check_reset("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // write sweep over every destination code
        for (int c = 1; c <= 8; c++) begin
            lo = 8'hC3 + 8'(c);
            exp_r[c] = (c == 7) ? {8'h00, lo} : 16'hA5C3 + 16'(c);
            step(1'b1, 4'(c), 16'hA5C3 + 16'(c), 1'b0, 4'd0, 1'b1, 1'b0);
        end
        idle();

        // wrap or saturate
        exp_r[1] = 16'hFFFF;
        step(1'b1, 4'd1, 16'hFFFF, 1'b0, 4'd0, 1'b1, 1'b0);
`ifdef INC_SATURATE_EN
        exp_r[1] = 16'hFFFF;
`else
        exp_r[1] = 16'h0000;
`endif
        step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd1, 1'b0, 1'b0);

        // same-register collision: write wins
        exp_r[6] = 16'h1234;
        step(1'b1, 4'd6, 16'h1234, 1'b1, 4'd6, 1'b1, 1'b0);
        exp_r[6] = 16'h1235;
        step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd6, 1'b0, 1'b0);

        // split collision: both commit
        exp_r[8] = 16'h00FF;
        step(1'b1, 4'd8, 16'h00FF, 1'b0, 4'd0, 1'b1, 1'b0);
        exp_r[2] = 16'h0055;
        exp_r[8] = 16'h0100;
        step(1'b1, 4'd2, 16'h0055, 1'b1, 4'd8, 1'b1, 1'b0);

        // illegal codes
        step(1'b1, 4'd12, 16'hDEAD, 1'b0, 4'd0, 1'b0, 1'b1);
        step(1'b0, 4'd0, 16'hDEAD, 1'b1, 4'd7, 1'b0, 1'b1);
        idle();
        step(1'b0, 4'd15, 16'hDEAD, 1'b0, 4'd0, 1'b0, 1'b0);
        exp_r[3] = 16'hA5C7;
        step(1'b1, 4'd0, 16'hDEAD, 1'b1, 4'd3, 1'b0, 1'b1);
        exp_r[5] = 16'h0000;
        step(1'b1, 4'd5, 16'h0000, 1'b1, 4'd0, 1'b1, 1'b1);
        idle();
        drain();

        // reset mid-cycle aborts a pending write
        @(negedge clk);
        bus.WRITE_EN  = 1'b1;
        bus.WRITE_SEL = 4'd1;
        bus.BUS_C     = 16'hBEEF;
        bus.INC_EN    = 1'b1;
        bus.INC_SEL   = 4'd3;
        #2 rst_n = 1'b0;
        #1 check_reset("midreset");
        @(posedge clk);
        #1 check_reset("heldreset");
        @(negedge clk);
        bus.WRITE_EN = 1'b0;
        bus.INC_EN   = 1'b0;
        rst_n = 1'b1;
        exp_r = '0;
        exp_r[4] = 16'h0042;
        step(1'b1, 4'd4, 16'h0042, 1'b0, 4'd0, 1'b1, 1'b0);
        idle();
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
